// File: rtl/if_biquad_pkg.sv
// Shared constants and types for the time-multiplexed IF biquad filter.
// Reset coefficients give the default 455 kHz band-pass response.
package if_biquad_pkg;

  localparam int unsigned NumTaps = 5;

  localparam logic [2:0] AddrB0 = 3'd0;
  localparam logic [2:0] AddrB1 = 3'd1;
  localparam logic [2:0] AddrB2 = 3'd2;
  localparam logic [2:0] AddrA1 = 3'd3;
  localparam logic [2:0] AddrA2 = 3'd4;

  localparam int RstB0 = 5;
  localparam int RstB1 = 0;
  localparam int RstB2 = -5;
  localparam int RstA1 = -16276;
  localparam int RstA2 = 8110;

  typedef enum logic [1:0] {StIdle, StMac, StWb, StDone} state_e;

  function automatic int rst_coef(int idx);
    case (idx)
      0:       return RstB0;
      1:       return RstB1;
      2:       return RstB2;
      3:       return RstA1;
      default: return RstA2;
    endcase
  endfunction

endpackage

// File: rtl/if_biquad_tdm_if.sv
// Sample/coefficient/result bundle between the IF front end and the biquad filter.
interface if_biquad_tdm_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned COEF_W   = 16
);
  logic                         sample_valid;
  logic [CHANNELS*DATA_W-1:0]   sample_in;
  logic [2:0]                   gain;
  logic                         coef_we;
  logic [2:0]                   coef_addr;
  logic [COEF_W-1:0]            coef_wdata;
  logic                         flag_clr;
  logic                         busy;
  logic                         out_valid;
  logic [CHANNELS*DATA_W-1:0]   out_data;
  logic                         overrun;
  logic                         sat_flag;

  modport master (
    output sample_valid, sample_in, gain, coef_we, coef_addr, coef_wdata, flag_clr,
    input  busy, out_valid, out_data, overrun, sat_flag
  );

  modport slave (
    input  sample_valid, sample_in, gain, coef_we, coef_addr, coef_wdata, flag_clr,
    output busy, out_valid, out_data, overrun, sat_flag
  );
endinterface

// File: rtl/if_biquad_mac.sv
// Shared multiply-accumulate plus shift-and-reduce of the biquad result.
// IF_BIQUAD_SAT_EN selects clamping reductions; otherwise results wrap.
module if_biquad_mac import if_biquad_pkg::*; #(
  parameter int unsigned COEF_W  = 16,
  parameter int unsigned STATE_W = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FRAC    = 13
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic                      sub_i,
  input  logic signed [COEF_W-1:0]  coef_i,
  input  logic signed [STATE_W-1:0] opnd_i,
  input  logic [2:0]                shift_i,
  output logic signed [STATE_W-1:0] y_o,
  output logic signed [DATA_W-1:0]  out_o,
  output logic                      sat_o
);

  localparam int unsigned AccW  = STATE_W + COEF_W + 3;
  localparam int unsigned ProdW = STATE_W + COEF_W;

  logic signed [ProdW-1:0]   mul;
  logic signed [AccW-1:0]    prod, acc_d, acc_q, y_full;
  logic signed [STATE_W-1:0] y_sh;

  assign mul = coef_i * opnd_i;

  always_comb begin
    prod  = {{(AccW-ProdW){mul[ProdW-1]}}, mul};
    acc_d = acc_q;
    if (en_i) begin
      acc_d = (clr_i ? '0 : acc_q) + (sub_i ? -prod : prod);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

`ifdef IF_BIQUAD_SAT_EN
  logic y_ovf, o_ovf;

  // Out of range whenever the bits above the target sign bit disagree with it.
  always_comb begin
    y_full = acc_q >>> FRAC;
    y_ovf  = (y_full[AccW-1:STATE_W-1] != '0) && (y_full[AccW-1:STATE_W-1] != '1);
    if (y_ovf) y_o = y_full[AccW-1] ? {1'b1, {(STATE_W-1){1'b0}}} : {1'b0, {(STATE_W-1){1'b1}}};
    else       y_o = y_full[STATE_W-1:0];
    y_sh   = y_o >>> shift_i;
    o_ovf  = (y_sh[STATE_W-1:DATA_W-1] != '0) && (y_sh[STATE_W-1:DATA_W-1] != '1);
    if (o_ovf) out_o = y_sh[STATE_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else       out_o = y_sh[DATA_W-1:0];
    sat_o  = y_ovf | o_ovf;
  end
`else
  logic unused_hi;

  always_comb begin
    y_full = acc_q >>> FRAC;
    y_o    = y_full[STATE_W-1:0];
    y_sh   = y_o >>> shift_i;
    out_o  = y_sh[DATA_W-1:0];
    sat_o  = 1'b0;
  end

  assign unused_hi = ^{y_full[AccW-1:STATE_W], y_sh[STATE_W-1:DATA_W]};
`endif

endmodule

// File: rtl/if_biquad_tdm.sv
// CHANNELS-way time-multiplexed IF biquad band-pass with shadowed coefficients.
// Saturation build selected by IF_BIQUAD_SAT_EN (see if_biquad_mac).
module if_biquad_tdm import if_biquad_pkg::*; #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned FRAC     = 13,
  parameter int unsigned STATE_W  = 16
) (
  input logic            clk,
  input logic            RSTb,
  if_biquad_tdm_if.slave bus
);

  localparam int unsigned ChW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned VecW    = CHANNELS * DATA_W;
  localparam logic [2:0]  LastTap = 3'(NumTaps - 1);
  localparam logic [ChW-1:0] LastCh = ChW'(CHANNELS - 1);

  state_e         state_q, state_d;
  logic [ChW-1:0] ch_q, ch_d;
  logic [2:0]     tap_q, tap_d;
  logic           busy, out_valid, mac_en, wb, accept, last_ch;

  logic [VecW-1:0] xin_q, xin_d, stage_q, stage_d, out_q, out_d;
  logic [2:0]      gain_q, gain_d;
  logic            overrun_q, overrun_d, sat_q, sat_d;
  logic signed [COEF_W-1:0]  shadow_q [NumTaps], shadow_d [NumTaps];
  logic signed [COEF_W-1:0]  active_q [NumTaps], active_d [NumTaps];
  logic signed [DATA_W-1:0]  x1_q [CHANNELS], x1_d [CHANNELS], x2_q [CHANNELS], x2_d [CHANNELS];
  logic signed [STATE_W-1:0] y1_q [CHANNELS], y1_d [CHANNELS], y2_q [CHANNELS], y2_d [CHANNELS];

  logic signed [DATA_W-1:0]  x_cur, out_new;
  logic signed [STATE_W-1:0] opnd, y_new;
  logic signed [COEF_W-1:0]  coef_sel;
  logic                      mac_sat;

  assign last_ch = (ch_q == LastCh);
  assign accept  = bus.sample_valid && !busy;

  always_ff @(posedge clk) begin
    if (!RSTb) begin
      state_q <= StIdle;
      ch_q    <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tap_q   <= tap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tap_d   = tap_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.sample_valid) begin
          state_d = StMac;
          ch_d    = '0;
          tap_d   = '0;
        end
      end
      StMac: begin
        if (tap_q == LastTap) begin
          state_d = StWb;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      StWb: begin
        if (last_ch) begin
          state_d = StDone;
        end else begin
          state_d = StMac;
          ch_d    = ch_q + ChW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StMac) || (state_q == StWb);
    out_valid = (state_q == StDone);
    mac_en    = (state_q == StMac);
    wb        = (state_q == StWb);
  end

  // Tap order b0..a2 lines up with the coefficient address map.
  always_comb begin
    x_cur = xin_q[int'(ch_q)*DATA_W +: DATA_W];
    case (tap_q)
      3'd0:    opnd = {{(STATE_W-DATA_W){x_cur[DATA_W-1]}}, x_cur};
      3'd1:    opnd = {{(STATE_W-DATA_W){x1_q[ch_q][DATA_W-1]}}, x1_q[ch_q]};
      3'd2:    opnd = {{(STATE_W-DATA_W){x2_q[ch_q][DATA_W-1]}}, x2_q[ch_q]};
      3'd3:    opnd = y1_q[ch_q];
      default: opnd = y2_q[ch_q];
    endcase
    case (tap_q)
      3'd0:    coef_sel = active_q[0];
      3'd1:    coef_sel = active_q[1];
      3'd2:    coef_sel = active_q[2];
      3'd3:    coef_sel = active_q[3];
      default: coef_sel = active_q[4];
    endcase
  end

  if_biquad_mac #(
    .COEF_W  (COEF_W),
    .STATE_W (STATE_W),
    .DATA_W  (DATA_W),
    .FRAC    (FRAC)
  ) u_mac (
    .clk_i   (clk),
    .rst_ni  (RSTb),
    .en_i    (mac_en),
    .clr_i   (tap_q == 3'd0),
    .sub_i   (tap_q >= AddrA1),
    .coef_i  (coef_sel),
    .opnd_i  (opnd),
    .shift_i (3'd7 - gain_q),
    .y_o     (y_new),
    .out_o   (out_new),
    .sat_o   (mac_sat)
  );

  always_comb begin
    xin_d    = xin_q;
    gain_d   = gain_q;
    shadow_d = shadow_q;
    active_d = active_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    stage_d  = stage_q;
    out_d    = out_q;
    if (bus.coef_we) begin
      case (bus.coef_addr)
        AddrB0:  shadow_d[0] = bus.coef_wdata;
        AddrB1:  shadow_d[1] = bus.coef_wdata;
        AddrB2:  shadow_d[2] = bus.coef_wdata;
        AddrA1:  shadow_d[3] = bus.coef_wdata;
        AddrA2:  shadow_d[4] = bus.coef_wdata;
        default: ;
      endcase
    end
    // Commit reads the old shadow, so a same-cycle write waits for the next accept.
    if (accept) begin
      xin_d    = bus.sample_in;
      gain_d   = bus.gain;
      active_d = shadow_q;
    end
    if (wb) begin
      x2_d[ch_q] = x1_q[ch_q];
      x1_d[ch_q] = x_cur;
      y2_d[ch_q] = y1_q[ch_q];
      y1_d[ch_q] = y_new;
      stage_d[int'(ch_q)*DATA_W +: DATA_W] = out_new;
      if (last_ch) out_d = stage_d;
    end
    overrun_d = bus.flag_clr ? 1'b0 : overrun_q;
    if (bus.sample_valid && busy) overrun_d = 1'b1;
    sat_d = bus.flag_clr ? 1'b0 : sat_q;
    if (wb && mac_sat) sat_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!RSTb) begin
      xin_q     <= '0;
      gain_q    <= '0;
      stage_q   <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < NumTaps; i++) begin
        shadow_q[i] <= COEF_W'(rst_coef(i));
        active_q[i] <= COEF_W'(rst_coef(i));
      end
      for (int c = 0; c < CHANNELS; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      xin_q     <= xin_d;
      gain_q    <= gain_d;
      stage_q   <= stage_d;
      out_q     <= out_d;
      overrun_q <= overrun_d;
      sat_q     <= sat_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_q;
  assign bus.overrun   = overrun_q;
  assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_if_biquad_tdm.sv
// Self-checking bench for if_biquad_tdm against a plain-arithmetic biquad model.
module tb_if_biquad_tdm;

  localparam int CH = 2;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int FR = 13;
  localparam int SW = 16;

  logic clk  = 1'b0;
  logic RSTb = 1'b0;
  always #5 clk = ~clk;

  if_biquad_tdm_if #(.CHANNELS(CH), .DATA_W(DW), .COEF_W(CW)) bus ();

  if_biquad_tdm #(
    .CHANNELS (CH),
    .DATA_W   (DW),
    .COEF_W   (CW),
    .FRAC     (FR),
    .STATE_W  (SW)
  ) dut (
    .clk  (clk),
    .RSTb (RSTb),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  longint sh [5], act [5];
  longint mx1 [CH], mx2 [CH], my1 [CH], my2 [CH], mout [CH], m_x [CH];
  bit     m_sat, m_ovr;

  task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint red(longint v, int w);
    longint mx, mn, m;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
`ifdef IF_BIQUAD_SAT_EN
    m = 0;
    if (v > mx) begin m_sat = 1'b1; return mx; end
    if (v < mn) begin m_sat = 1'b1; return mn; end
    return v + m;
`else
    m = longint'(1) <<< w;
    v = v & (m - 1);
    if (v > mx) v = v - m;
    return v;
`endif
  endfunction

  task automatic model_reset();
    sh = '{5, 0, -5, -16276, 8110};
    act = sh;
    for (int c = 0; c < CH; c++) begin
      mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0; mout[c] = 0;
    end
    m_sat = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_accept(int g);
    longint acc, y, ys;
    act = sh;
    for (int c = 0; c < CH; c++) begin
      acc = act[0]*m_x[c] + act[1]*mx1[c] + act[2]*mx2[c] - act[3]*my1[c] - act[4]*my2[c];
      y   = acc >>> FR;
      ys  = red(y, SW);
      mout[c] = red(ys >>> (7 - g), DW);
      mx2[c] = mx1[c]; mx1[c] = m_x[c];
      my2[c] = my1[c]; my1[c] = ys;
    end
  endtask

  task automatic wcoef(int a, longint v);
    @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = a[2:0];
    bus.coef_wdata = CW'(v);
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (a < 5) sh[a] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    RSTb = 1'b0;
    @(negedge clk);
    RSTb = 1'b1;
    model_reset();
  endtask

  task automatic clear_flags();
    @(negedge clk);
    bus.flag_clr = 1'b1;
    @(negedge clk);
    bus.flag_clr = 1'b0;
    m_ovr = 1'b0;
    m_sat = 1'b0;
    check("overrun_clr", bus.overrun, 0);
    check("sat_clr", bus.sat_flag, 0);
  endtask

  // One sample through the filter; optional drop/coef-write/reset injection at cycle k.
  task automatic run(longint x0, longint x1, int g, int drop_at, int coef_at, longint cval,
                     int rst_at);
    longint prev [CH];
    int     ovc, bc, holdbad;
    bit     got;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_in    = {DW'(x1), DW'(x0)};
    bus.gain         = g[2:0];
    prev = mout;
    m_x[0] = x0;
    m_x[1] = x1;
    @(posedge clk);
    model_accept(g);
    got = 1'b0; ovc = 0; bc = 0; holdbad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.coef_we      = 1'b0;
      RSTb             = 1'b1;
      if (drop_at != 0 && k == drop_at) check("overrun_before", bus.overrun, m_ovr);
      if (drop_at != 0 && k == drop_at + 1) check("overrun_set", bus.overrun, 1);
      if (bus.busy) begin
        bc++;
        for (int c = 0; c < CH; c++)
          if ($signed(bus.out_data[c*DW +: DW]) != prev[c]) holdbad++;
      end
      if (k == drop_at) begin
        bus.sample_valid = 1'b1;
        bus.sample_in    = ~bus.sample_in;
        m_ovr            = 1'b1;
      end
      if (k == coef_at) begin
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 3'd0;
        bus.coef_wdata = CW'(cval);
        sh[0]          = cval;
      end
      if (k == rst_at) begin
        RSTb = 1'b0;
        model_reset();
      end
      if (bus.out_valid) begin
        got = 1'b1;
        ovc = k;
        break;
      end
    end
    if (rst_at != 0) begin
      check("no_valid_after_reset", got, 0);
    end else begin
      check("valid_cycle", ovc, 13);
      check("busy_cycles", bc, 12);
      check("busy_at_valid", bus.busy, 0);
      check("out_hold", holdbad, 0);
    end
    for (int c = 0; c < CH; c++)
      check($sformatf("out_ch%0d", c), $signed(bus.out_data[c*DW +: DW]), mout[c]);
    check("overrun", bus.overrun, m_ovr);
    check("sat_flag", bus.sat_flag, m_sat);
  endtask

  function automatic logic signed [63:0] out_ch(int c);
    return $signed(bus.out_data[c*DW +: DW]);
  endfunction

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.gain         = 3'd0;
    bus.coef_we      = 1'b0;
    bus.coef_addr    = 3'd0;
    bus.coef_wdata   = '0;
    bus.flag_clr     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    RSTb = 1'b1;
    @(negedge clk);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_sat", bus.sat_flag, 0);

    // Default coefficients: 5*100 >>> 13 = 0
    run(100, 0, 7, 0, 0, 0, 0);
    check("default_impulse", out_ch(0), 0);

    // Passthrough
    wcoef(0, 8192); wcoef(1, 0); wcoef(2, 0); wcoef(3, 0); wcoef(4, 0);
    run(100, -37, 7, 0, 0, 0, 0);
    check("pass_g7_ch0", out_ch(0), 100);
    check("pass_g7_ch1", out_ch(1), -37);
    run(100, -37, 5, 0, 0, 0, 0);
    check("pass_g5_ch0", out_ch(0), 25);
    check("pass_g5_ch1", out_ch(1), -10);

    // Recursion: y halves each sample
    do_reset();
    wcoef(0, 8192); wcoef(1, 0); wcoef(2, 0); wcoef(3, -4096); wcoef(4, 0);
    for (int i = 0; i < 5; i++) begin
      run((i == 0) ? 64 : 0, 0, 7, 0, 0, 0, 0);
      check($sformatf("recur_%0d", i), out_ch(0), 64 >>> i);
      check($sformatf("recur_ch1_%0d", i), out_ch(1), 0);
    end

    // Saturation / wrap
    do_reset();
    wcoef(0, 32767); wcoef(1, 0); wcoef(2, 0); wcoef(3, 0); wcoef(4, 0);
    run(100, 0, 7, 0, 0, 0, 0);
`ifdef IF_BIQUAD_SAT_EN
    check("sat_out", out_ch(0), 127);
    check("sat_flag_set", bus.sat_flag, 1);
`else
    check("wrap_out", out_ch(0), -113);
    check("wrap_flag", bus.sat_flag, 0);
`endif
    clear_flags();
    run(100, 0, 5, 0, 0, 0, 0);
    check("sat_g5", out_ch(0), 99);

    // Overrun: sample during busy is dropped
    run(10, 20, 7, 4, 0, 0, 0);
    clear_flags();

    // Shadow commit: write mid-computation lands on the next sample
    run(50, 0, 7, 0, 3, 8192, 0);
    run(50, 0, 7, 0, 0, 0, 0);
    check("shadow_new_b0", out_ch(0), 50);

    // Reset mid-computation aborts the result
    run(30, 30, 7, 0, 0, 0, 5);

    // Randomised stream with occasional coefficient updates
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) begin
        wcoef(0, longint'($urandom_range(0, 16383)) - 8192);
        wcoef(3, longint'($urandom_range(0, 16383)) - 8192);
        wcoef(4, longint'($urandom_range(0, 4095)));
      end
      run(longint'($urandom_range(0, 255)) - 128, longint'($urandom_range(0, 255)) - 128,
          int'($urandom_range(0, 7)), 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_biquad_tdm.md
# if_biquad_tdm

Parametrised, time-multiplexed second-order IIR IF band-pass filter serving CHANNELS independent sample streams through one shared multiplier. Successor to the fixed 455 kHz IF filter: runtime-programmable coefficients with shadow/commit, per-sample gain shift, optional saturation, and a valid/busy handshake. Sits between the IF mixer/decimator and the AM demodulator.

## Interface
- CHANNELS, 2: independent filter channels
- DATA_W, 8: input/output sample width (signed)
- COEF_W, 16: coefficient width (signed)
- FRAC, 13: coefficient fractional bits (a0 ≡ 2^FRAC)
- STATE_W, 16: stored y-state width (signed)
- clk  in  1  system clock
- RSTb  in  1  reset; one clock; reset is synchronous and active-low
- sample_valid  in  1  input strobe
- sample_in  in  CHANNELS*DATA_W  channel c at [c*DATA_W +: DATA_W]
- gain  in  3  output gain 0..7, sampled on accept
- coef_we  in  1  shadow coefficient write strobe
- coef_addr  in  3  0 b0, 1 b1, 2 b2, 3 a1, 4 a2; 5..7 ignored
- coef_wdata  in  COEF_W  coefficient value
- flag_clr  in  1  clears overrun and sat_flag
- busy  out  1  computation in progress
- out_valid  out  1  one-cycle result strobe
- out_data  out  CHANNELS*DATA_W  filtered samples, same packing as input
- overrun  out  1  sticky: sample_valid dropped while busy
- sat_flag  out  1  sticky: a saturation occurred

## Operation
- Per channel: acc = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2]; y[n] = acc >>> FRAC (arithmetic, truncating).
- acc width STATE_W+COEF_W+3; x sign-extended; no intermediate overflow.
- y[n] reduced to STATE_W, stored as y-state; x history stores raw DATA_W inputs.
- Output per channel: y[n] >>> (7 − gain), reduced to DATA_W.
- Accept: sample_valid && !busy. Latches sample_in and gain, commits shadow coefficients to active set.
- FSM: IDLE → MAC(ch, tap 0..4) → WB(ch) → next ch MAC … → after last WB: DONE → IDLE.
- MAC: one product per cycle into accumulator cleared at tap 0. WB: update y/x history for channel, store output byte.
- Coefficient writes go to shadow regs any cycle; active set changes only on accept. Write in accept cycle lands in shadow, committed next accept.
- sample_valid while busy: dropped, overrun ← 1. flag_clr and a new set event in same cycle: set wins.
- Reset: out_data 0, out_valid 0, busy 0, flags 0, all history 0, FSM IDLE; shadow and active coefficients ← b0 5, b1 0, b2 −5, a1 −16276, a2 8110. Reset mid-computation aborts; no out_valid.

## Timing
- Accept edge = cycle 0; busy high cycles 1..6·CHANNELS; out_valid high cycle 6·CHANNELS+1 (13 for CHANNELS=2), busy low that cycle.
- Sample accepted in out_valid cycle is legal; max rate one per 6·CHANNELS+1 cycles.
- out_data updates only with out_valid; holds otherwise. Flags registered, visible cycle after event.

## Configuration
- IF_BIQUAD_SAT_EN defined: y-state and output clamp to signed range of STATE_W / DATA_W; any clamp sets sat_flag.
- Undefined: both reductions take low bits (two's-complement wrap); sat_flag tied 0.

## Structure
- Package if_biquad_pkg: coefficient address constants, reset coefficient values, FSM state typedef, tap count (5).
- One sub-module if_biquad_mac: signed multiply, accumulate, shift-and-reduce (sat/wrap per macro).

## Test plan
- Reset defaults: after RSTb low, read back behaviour: x=100 impulse ch0, gain 7 → out 0 (5·100>>>13), busy/out_valid per timing, out_valid at cycle 13.
- Passthrough: b0=8192 others 0, gain 7, x=100/−37 → out 100/−37; gain 5 → 25/−10.
- Recursion: b0=8192, a1=−4096, impulse 64 then zeros, gain 7 → 64, 32, 16, 8, 4; ch1 stays 0.
- Saturation: b0=32767, x=100, gain 7 → y=399, out 127, sat_flag=1 (SAT_EN); without macro out −113, sat_flag 0; gain 5 → 99 both builds.
- Overrun: sample_valid at cycle 4 after accept → ignored, outputs unchanged, overrun=1; flag_clr → 0.
- Shadow commit: write b0=8192 at cycle 3 of computation → current result uses old b0; next accepted sample uses new.
